// File: rtl/tx_scheduler.sv
// Round-robin scheduler sharing one packet_sender among N_REQ sources.
// One grant per frame; the next grant waits until the sender's frame has drained.
module tx_scheduler #(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned START_TIMEOUT = 4,
    parameter int unsigned IW            = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter type         packet_t      = logic [31:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req_valid,
    input  packet_t          req_pkt [N_REQ],
    output logic [N_REQ-1:0] req_ack,
    output logic             snd_valid,
    output packet_t          snd_pkt,
    input  logic             snd_busy,
    output logic [IW-1:0]    grant_id,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);

    localparam int unsigned CW = $clog2(START_TIMEOUT);

    localparam logic [1:0] S_ARB        = 2'd0;
    localparam logic [1:0] S_ISSUE      = 2'd1;
    localparam logic [1:0] S_WAIT_START = 2'd2;
    localparam logic [1:0] S_WAIT_END   = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] cnt;
    logic [IW-1:0] scan_idx;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic          grant;

    // First pending requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = IW'((32'(rr_ptr) + i) % N_REQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Outputs are qualified by rst so nothing leaks out while reset is held.
    assign grant      = rst && en && !snd_busy && win_found && (state == S_ARB);
    assign snd_valid  = rst && (state == S_ISSUE);
    assign frame_done = rst && (state == S_WAIT_END) && !snd_busy;
    assign busy       = (state != S_ARB);

    always_comb begin
        req_ack = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ack[i] = grant && (win_idx == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_ARB;
            rr_ptr   <= '0;
            grant_id <= '0;
            snd_pkt  <= '0;
            err      <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                S_ARB: begin
                    if (grant) begin
                        snd_pkt  <= req_pkt[win_idx];
                        grant_id <= win_idx;
                        rr_ptr   <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (snd_busy) begin
                        state <= S_WAIT_END;
                    end else if (cnt == CW'(START_TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= S_ARB;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (!snd_busy) begin
                        state <= S_ARB;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// Scoreboard bench for tx_scheduler: expected grants are queued as stimulus is
// driven and matched against req_ack / snd_valid as the scheduler produces them.
module tb_tx_scheduler;

    localparam int N = 4;
    localparam int BUSY_LEN = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N-1:0]  req_valid;
    logic [31:0]   req_pkt [N];
    logic [N-1:0]  req_ack;
    logic          snd_valid;
    logic [31:0]   snd_pkt;
    logic          snd_busy = 1'b0;
    logic [1:0]    grant_id;
    logic          busy;
    logic          frame_done;
    logic          err;

    typedef struct {
        int          id;
        logic [31:0] pkt;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   ack_count = 0;
    int   sv_count = 0;
    int   fd_count = 0;
    logic sender_dead = 1'b0;

    tx_scheduler #(
        .N_REQ         (N),
        .START_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req_valid  (req_valid),
        .req_pkt    (req_pkt),
        .req_ack    (req_ack),
        .snd_valid  (snd_valid),
        .snd_pkt    (snd_pkt),
        .snd_busy   (snd_busy),
        .grant_id   (grant_id),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Sender model: busy rises the cycle after snd_valid and stays up BUSY_LEN cycles.
    always begin
        int  left;
        logic pend;
        left = 0;
        pend = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (left > 0) begin
                left--;
                if (left == 0) snd_busy = 1'b0;
            end
            if (pend && !sender_dead) begin
                snd_busy = 1'b1;
                left = BUSY_LEN;
            end
            pend = snd_valid;
        end
    end

    // Output monitor: acks peek the scoreboard head, issues pop it.
    always @(negedge clk) begin
        if (|req_ack) begin
            ack_count++;
            if (sbq.size() == 0) check_val("ack_unexpected", {60'd0, req_ack}, 64'd0);
            else check_val("req_ack", {60'd0, req_ack}, 64'd1 << sbq[0].id);
        end
        if (snd_valid) begin
            sv_count++;
            if (sbq.size() == 0) begin
                check_val("issue_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check_val("grant_id", {62'd0, grant_id}, 64'(e.id));
                check_val("snd_pkt", {32'd0, snd_pkt}, {32'd0, e.pkt});
                check_val("busy_on_issue", {63'd0, busy}, 64'd1);
            end
        end
        if (frame_done) fd_count++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // sel: 0 = ack count, 1 = snd_valid count, 2 = frame_done count
    task automatic wait_reach(input int sel, input int target, input string tag);
        int n;
        int v;
        n = 0;
        v = (sel == 0) ? ack_count : (sel == 1) ? sv_count : fd_count;
        while (v < target && n < 300) begin
            tick(1);
            n++;
            v = (sel == 0) ? ack_count : (sel == 1) ? sv_count : fd_count;
        end
        if (v < target) check_val(tag, 64'(v), 64'(target));
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id = id;
        e.pkt = req_pkt[id];
        sbq.push_back(e);
    endtask

    initial begin
        int a0;
        int f0;
        for (int i = 0; i < N; i++) req_pkt[i] = 32'hC0DE_0000 + 32'(i) * 32'h0101_1111;
        rst = 1'b0;
        en = 1'b1;
        req_valid = 4'hF;

        // Reset with every requester pending
        tick(2);
        @(negedge clk);
        check_val("rst_req_ack", {60'd0, req_ack}, 64'd0);
        check_val("rst_snd_valid", {63'd0, snd_valid}, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_err", {63'd0, err}, 64'd0);
        check_val("rst_frame_done", {63'd0, frame_done}, 64'd0);
        check_val("rst_grant_id", {62'd0, grant_id}, 64'd0);
        check_val("rst_snd_pkt", {32'd0, snd_pkt}, 64'd0);
        for (int k = 0; k < 5; k++) push_exp(k % N);
        tick(1);
        rst = 1'b1;
        @(negedge clk);
        check_val("first_ack", {60'd0, req_ack}, 64'd1);
        @(negedge clk);
        check_val("first_issue", {63'd0, snd_valid}, 64'd1);

        // Continuous requests: order 0,1,2,3,0
        wait_reach(1, 5, "rr_issue_timeout");
        req_valid = '0;
        wait_reach(2, 5, "rr_done_timeout");
        tick(3);
        check_val("rr_issue_count", 64'(sv_count), 64'd5);
        check_val("rr_done_count", 64'(fd_count), 64'd5);

        // rr_ptr=1: only 2 pending -> 2 (rr=3); again wraps to 2; then {0,3} -> 3
        for (int k = 0; k < 3; k++) begin
            a0 = ack_count;
            f0 = fd_count;
            push_exp((k == 2) ? 3 : 2);
            req_valid = (k == 2) ? 4'b1001 : 4'b0100;
            wait_reach(0, a0 + 1, "wrap_ack_timeout");
            req_valid = '0;
            wait_reach(2, f0 + 1, "wrap_done_timeout");
        end

        // Dead sender: rr=0, requester 1 -> start timeout, then regrant of 1
        sender_dead = 1'b1;
        push_exp(1);
        push_exp(1);
        req_valid = 4'b0010;
        a0 = sv_count;
        wait_reach(1, a0 + 1, "dead_issue_timeout");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("dead_err_low", {63'd0, err}, 64'd0);
            check_val("dead_busy_high", {63'd0, busy}, 64'd1);
        end
        @(negedge clk);
        check_val("dead_err_set", {63'd0, err}, 64'd1);
        check_val("dead_back_arb", {63'd0, busy}, 64'd0);
        wait_reach(1, a0 + 2, "dead_reissue_timeout");
        req_valid = '0;
        tick(8);
        sender_dead = 1'b0;
        tick(2);
        check_val("err_sticky", {63'd0, err}, 64'd1);
        check_val("dead_idle", {63'd0, busy}, 64'd0);

        // Enable gating: rr=2
        en = 1'b0;
        req_valid = 4'b1000;
        a0 = ack_count;
        tick(5);
        check_val("en_low_no_ack", 64'(ack_count), 64'(a0));
        push_exp(3);
        req_valid = 4'b1001;
        en = 1'b1;
        f0 = fd_count;
        wait_reach(0, a0 + 1, "en_ack_timeout");
        req_valid = 4'b0001;
        tick(4);
        en = 1'b0;
        wait_reach(2, f0 + 1, "en_done_timeout");
        tick(6);
        check_val("en_low_frame_done", 64'(fd_count), 64'(f0 + 1));
        check_val("en_low_no_regrant", 64'(ack_count), 64'(a0 + 1));
        push_exp(0);
        en = 1'b1;
        wait_reach(0, a0 + 2, "en_reack_timeout");
        req_valid = '0;
        wait_reach(2, f0 + 2, "en_redone_timeout");

        // Reset in S_WAIT_END with the sender busy: rr=1
        push_exp(1);
        req_valid = 4'b0010;
        a0 = ack_count;
        wait_reach(0, a0 + 1, "mid_ack_timeout");
        req_valid = '0;
        tick(4);
        f0 = fd_count;
        check_val("mid_in_frame", {62'd0, snd_busy, busy}, 64'd3);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_busy", {63'd0, busy}, 64'd0);
        check_val("mid_rst_snd_valid", {63'd0, snd_valid}, 64'd0);
        check_val("mid_rst_err", {63'd0, err}, 64'd0);
        tick(15);
        check_val("mid_rst_no_done", 64'(fd_count), 64'(f0));
        check_val("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
